ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It is the opposite direction to the keyboard receive path, and it sends command bytes to the keyboard, e.g. 0xED for set LEDs or 0xFF for reset, written by the PicoBlaze. It drives PS2c/PS2d open-collector through pull-low enables, follows the device-generated clock, and checks the device acknowledge. While a frame is in flight it asserts an inhibit output toward the PS/2 receive driver.

Parameters:
INHIBIT_CYCLES, 10000, number of CLK cycles the host holds PS2c low before the request (100 us at 100 MHz).
TIMEOUT_CYCLES, 2000000, watchdog in CLK cycles from request-to-send until the ack is sampled (20 ms).
FILTER_LEN, 8, number of consecutive equal synchronized PS2c samples required to change the filtered clock level.

Ports:
CLK  input  1  system clock.
Reset  input  1  asynchronous, active-low reset.
Tx_Start  input  1  one-cycle request to send Tx_Data; accepted only in IDLE.
Tx_Data  input  8  command byte; latched on an accepted Tx_Start.
PS2c_in  input  1  pad level of the PS/2 clock line (asynchronous).
PS2d_in  input  1  pad level of the PS/2 data line (asynchronous).
PS2c_oe  output  1  1 = pull PS2c low; 0 = release the line.
PS2d_oe  output  1  1 = pull PS2d low; 0 = release the line.
Tx_Busy  output  1  high in every state except IDLE.
Tx_Done  output  1  one-cycle pulse: frame acknowledged by the device and bus back to idle.
Tx_Err  output  1  one-cycle pulse: NACK or watchdog expiry.
Rx_Inhibit  output  1  equal to Tx_Busy; the receiver discards bits while this is high.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State returns to IDLE.
  - All outputs are 0, so both lines are released.
  - Counters, the shift register and the filter clear; the filtered PS2c level resets to 1.
- Input conditioning:
  - PS2c_in and PS2d_in each pass through a 2-flop synchronizer.
  - The synchronized PS2c feeds the FILTER_LEN filter.
  - fall = filtered level goes 1 to 0; this is one CLK pulse.
- Start: Tx_Start in IDLE latches the frame shift register
  - sr = {stop=1, parity=~^Tx_Data, Tx_Data}, 10 bits, shifted out LSB first.
  - bitcnt is set to 0, and the state goes to INHIBIT on the next edge.
  - Tx_Start in any other state is ignored.
- INHIBIT:
  - PS2c_oe=1 and PS2d_oe=0.
  - After exactly INHIBIT_CYCLES cycles, go to REQ.
- REQ:
  - PS2d_oe=1 (start bit 0) is asserted in the same cycle PS2c_oe drops to 0.
  - The watchdog loads TIMEOUT_CYCLES.
  - The state goes to SEND.
- SEND:
  - On each fall: PS2d_oe <= ~sr[0], sr shifts right, bitcnt increments.
  - The 1st fall presents data bit 0, falls 2 to 8 present bits 1 to 7, the 9th presents parity, and the 10th presents stop (line released).
  - After the 10th fall, go to ACK.
- ACK:
  - On the next fall (the 11th), sample synchronized PS2d.
  - 0 = ACK: go to WAIT_IDLE.
  - 1 = NACK: pulse Tx_Err and go to IDLE.
- WAIT_IDLE:
  - Wait until the filtered PS2c and synchronized PS2d are both 1.
  - Then pulse Tx_Done and go to IDLE.
- Watchdog:
  - Decrements in REQ, SEND and ACK.
  - On reaching 0: both oe=0, Tx_Err pulses, and the state goes to IDLE at once, whatever the bit count.
- Timing rules:
  - Data changes only on fall; PS2d_oe never changes while the filtered clock is low except at the REQ entry.
  - Tx_Done and Tx_Err are mutually exclusive and never both asserted.
- Reset mid-frame: both lines are released within the same cycle, because the reset is asynchronous. No Done/Err pulse is produced.

Test Plan:
- Bench setup: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=5000, FILTER_LEN=4; the device model runs PS2c at a 100-cycle period.
- Send 0xED with the device giving ACK:
  - PS2c held low for exactly 20 cycles, then start bit 0.
  - Device samples bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - ACK on the 11th fall; exactly one Tx_Done pulse; Tx_Busy falls in the same cycle.
- Send 0xF4 (five 1s): device samples parity 0; ACK gives Tx_Done; Tx_Err stays 0 throughout.
- Device NACK (holds PS2d high on the ack clock) on 0xFF: one Tx_Err pulse, no Tx_Done, both oe=0, state IDLE.
- Device never clocks after the request: Tx_Err pulses exactly 5000 cycles after REQ entry, and both lines are released.
- Reset asserted low after the 4th fall of a frame: PS2c_oe and PS2d_oe are 0 asynchronously, with no Done/Err. A new Tx_Start of 0xED after release completes normally.
- Tx_Start pulsed during SEND with 0x00: ignored; the frame in flight still carries its original byte, and only one Tx_Done is produced.
- 2-cycle glitch low on PS2c_in: no fall detected and the bit count is unchanged.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with device ack check and watchdog
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Tx_Start,
  input  logic [7:0] Tx_Data,
  input  logic       PS2c_in,
  input  logic       PS2d_in,
  output logic       PS2c_oe,
  output logic       PS2d_oe,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_Err,
  output logic       Rx_Inhibit
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    c_sync_q, c_sync_d;
  logic [1:0]    d_sync_q, d_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [9:0]    sr_q, sr_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          c_oe_q, c_oe_d;
  logic          d_oe_q, d_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          c_s, d_s, step, flip, fall, timeout;

  assign c_s     = c_sync_q[1];
  assign d_s     = d_sync_q[1];
  assign step    = c_s != filt_q;
  assign flip    = step && fcnt_q == FW'(FILTER_LEN - 1);
  assign fall    = flip && filt_q;
  assign timeout = (state_q == REQ || state_q == SEND || state_q == ACK) && wdog_q == WW'(1);

  assign PS2c_oe    = c_oe_q;
  assign PS2d_oe    = d_oe_q;
  assign Tx_Done    = done_q;
  assign Tx_Err     = err_q;
  assign Tx_Busy    = state_q != IDLE;
  assign Rx_Inhibit = Tx_Busy;

  // Synchronize both pads and debounce the clock: the level flips only after FILTER_LEN differing samples
  always_comb begin
    c_sync_d = {c_sync_q[0], PS2c_in};
    d_sync_d = {d_sync_q[0], PS2d_in};
    fcnt_d   = (step && !flip) ? fcnt_q + FW'(1) : '0;
    filt_d   = flip ? c_s : filt_q;
  end

  // Frame sequencer: inhibit, request-to-send, shift on device clock falls, ack, wait for idle bus
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    icnt_d   = icnt_q;
    wdog_d   = (state_q == REQ || state_q == SEND || state_q == ACK) ? wdog_q - WW'(1) : wdog_q;
    c_oe_d   = c_oe_q;
    d_oe_d   = d_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (Tx_Start) begin
        sr_d     = {1'b1, ~^Tx_Data, Tx_Data};
        bitcnt_d = '0;
        icnt_d   = '0;
        c_oe_d   = 1'b1;
        state_d  = INHIBIT;
      end
      INHIBIT: if (icnt_q == IW'(INHIBIT_CYCLES - 1)) begin
        c_oe_d  = 1'b0;
        d_oe_d  = 1'b1;
        wdog_d  = WW'(TIMEOUT_CYCLES);
        state_d = REQ;
      end else begin
        icnt_d = icnt_q + IW'(1);
      end
      REQ: state_d = SEND;
      SEND: if (fall) begin
        d_oe_d   = ~sr_q[0];
        sr_d     = {1'b0, sr_q[9:1]};
        bitcnt_d = bitcnt_q + 4'd1;
        state_d  = (bitcnt_q == 4'd9) ? ACK : SEND;
      end
      ACK: if (fall) begin
        err_d   = d_s;
        state_d = d_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (filt_q && d_s) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      c_oe_d  = 1'b0;
      d_oe_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  // State register; the lines are released the moment reset asserts
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      sr_q     <= '0;
      bitcnt_q <= '0;
      icnt_q   <= '0;
      wdog_q   <= '0;
      c_oe_q   <= 1'b0;
      d_oe_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_sync_q <= c_sync_d;
      d_sync_q <= d_sync_d;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      icnt_q   <= icnt_d;
      wdog_q   <= wdog_d;
      c_oe_q   <= c_oe_d;
      d_oe_q   <= d_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and random frames against a PS/2 device model and a frame reference model
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 5000;
  localparam int FLT = 4;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       Tx_Start = 1'b0;
  logic [7:0] Tx_Data = 8'h00;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       pc, pd;
  logic       PS2c_oe, PS2d_oe, Tx_Busy, Tx_Done, Tx_Err, Rx_Inhibit;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit both_seen = 1'b0;

  assign pc = ~PS2c_oe & dev_c;
  assign pd = ~PS2d_oe & dev_d;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .CLK(CLK), .Reset(Reset), .Tx_Start(Tx_Start), .Tx_Data(Tx_Data),
    .PS2c_in(pc), .PS2d_in(pd), .PS2c_oe(PS2c_oe), .PS2d_oe(PS2d_oe),
    .Tx_Busy(Tx_Busy), .Tx_Done(Tx_Done), .Tx_Err(Tx_Err), .Rx_Inhibit(Rx_Inhibit)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (Tx_Done === 1'b1) done_cnt++;
    if (Tx_Err === 1'b1) err_cnt++;
    if (Tx_Done === 1'b1 && Tx_Err === 1'b1) both_seen = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish within its time budget");
    $fatal(1);
  end

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected device-side frame: data LSB first, odd parity, stop bit 1
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones = 0;
    logic p;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    p = (ones % 2 == 0);
    return {1'b1, p, b};
  endfunction

  task automatic start_req(input logic [7:0] b);
    int n = 0;
    Tx_Data = b;
    Tx_Start = 1'b1;
    tick;
    Tx_Start = 1'b0;
    while (PS2c_oe === 1'b1 && n < 200) begin
      n++;
      tick;
    end
    chk("inhibit_len", n, INH);
    chk("req_start_bit", {PS2c_oe, PS2d_oe, pd}, 3'b010);
    chk("busy_inhibit", {Tx_Busy, Rx_Inhibit}, 2'b11);
  endtask

  task automatic device(input int nfalls, input bit ack, input int abort_at, input int inject_at,
                        input int glitch_at, output logic [9:0] got);
    got = '0;
    repeat (20) tick;
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11 && ack) dev_d = 1'b0;
      dev_c = 1'b0;
      repeat (10) tick;
      if (i == abort_at) return;
      if (i == inject_at) begin
        Tx_Data = 8'h00;
        Tx_Start = 1'b1;
        tick;
        Tx_Start = 1'b0;
        repeat (39) tick;
      end else begin
        repeat (40) tick;
      end
      dev_c = 1'b1;
      repeat (25) tick;
      if (i <= 10) got[i-1] = pd;
      if (i == glitch_at) begin
        dev_c = 1'b0;
        repeat (2) tick;
        dev_c = 1'b1;
        repeat (23) tick;
      end else begin
        repeat (25) tick;
      end
      if (i == 11) dev_d = 1'b1;
    end
  endtask

  task automatic frame_ok(input logic [7:0] b, input int inject_at, input int glitch_at, input string tag);
    int d0 = done_cnt;
    int e0 = err_cnt;
    int n = 0;
    logic pb;
    logic [9:0] got;
    start_req(b);
    device(11, 1'b1, 0, inject_at, glitch_at, got);
    chk({tag, "_bits"}, got, frame_of(b));
    pb = Tx_Busy;
    while (Tx_Done !== 1'b1 && n < 500) begin
      pb = Tx_Busy;
      tick;
      n++;
    end
    chk({tag, "_done"}, Tx_Done, 1'b1);
    chk({tag, "_busy_drop"}, {pb, Tx_Busy, Rx_Inhibit}, 3'b100);
    repeat (5) tick;
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_err_cnt"}, err_cnt - e0, 0);
    chk({tag, "_lines"}, {PS2c_oe, PS2d_oe}, 2'b00);
  endtask

  initial begin
    logic [9:0] got;
    int d0, e0, n;
    tick;
    chk("reset_outputs", {PS2c_oe, PS2d_oe, Tx_Busy, Tx_Done, Tx_Err, Rx_Inhibit}, 6'b0);
    Reset = 1'b1;
    repeat (5) tick;
    chk("idle_outputs", {PS2c_oe, PS2d_oe, Tx_Busy, Tx_Done, Tx_Err, Rx_Inhibit}, 6'b0);

    frame_ok(8'hED, 0, 0, "ed");
    frame_ok(8'hF4, 0, 0, "f4");

    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'hFF);
    device(11, 1'b0, 0, 0, 0, got);
    chk("nack_bits", got, frame_of(8'hFF));
    repeat (5) tick;
    chk("nack_err_cnt", err_cnt - e0, 1);
    chk("nack_done_cnt", done_cnt - d0, 0);
    chk("nack_idle", {PS2c_oe, PS2d_oe, Tx_Busy}, 3'b000);

    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'h3C);
    n = 0;
    while (Tx_Err !== 1'b1 && n < TMO + 1000) begin
      tick;
      n++;
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_lines", {PS2c_oe, PS2d_oe, Tx_Busy}, 3'b000);
    repeat (5) tick;
    chk("timeout_err_cnt", err_cnt - e0, 1);
    chk("timeout_done_cnt", done_cnt - d0, 0);

    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'hA5);
    device(4, 1'b0, 4, 0, 0, got);
    chk("pre_reset_lines", {PS2c_oe, PS2d_oe, Tx_Busy}, 3'b011);
    #2 Reset = 1'b0;
    #1 chk("async_release", {PS2c_oe, PS2d_oe, Tx_Busy, Tx_Done, Tx_Err}, 5'b0);
    repeat (3) tick;
    Reset = 1'b1;
    dev_c = 1'b1;
    dev_d = 1'b1;
    repeat (10) tick;
    chk("reset_no_done", done_cnt - d0, 0);
    chk("reset_no_err", err_cnt - e0, 0);
    frame_ok(8'hED, 0, 0, "after_reset");

    frame_ok(8'h5A, 3, 0, "inject");
    frame_ok(8'hC3, 0, 5, "glitch");

    for (int k = 0; k < 4; k++) frame_ok(8'($urandom), 0, 0, "random");

    chk("done_err_exclusive", both_seen, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
